// File: rtl/prog_sequencer.sv
// Program-buffer sequencer that issues instructions to the cpu via the s/load/w handshake.
// Optional single-step hold between instructions: define PROG_SEQUENCER_STEP_EN.
module prog_sequencer #(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       ADDR_W      = 4,
    parameter int unsigned       ISSUE_CYC   = 2,
    parameter int unsigned       TIMEOUT_CYC = 64,
    parameter logic [DATA_W-1:0] HALT_OP     = 16'hE000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_wdata,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              step,
    input  logic              cpu_w,
    output logic              cpu_s,
    output logic              cpu_load,
    output logic [DATA_W-1:0] cpu_in,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned     Depth   = 2 ** ADDR_W;
    localparam int unsigned     IssW    = (ISSUE_CYC > 1) ? $clog2(ISSUE_CYC) : 1;
    localparam int unsigned     TmoW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IssW-1:0] IssLast = IssW'(ISSUE_CYC - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle, StFetch, StIssue, StWaitAck, StWaitDone, StHalt, StStepHold
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   mem [Depth];
    logic [DATA_W-1:0]   cur_instr;
    // idx counts one past the buffer so len=Depth terminates; pc is its saturated view
    logic [ADDR_W:0]     idx_q, idx_d, len_q, len_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [IssW-1:0]     iss_q, iss_d;
    logic [TmoW-1:0]     tmo_q, tmo_d;
    logic                cpu_s_q, cpu_s_d, cpu_load_q, cpu_load_d;
    logic [DATA_W-1:0]   cpu_in_q, cpu_in_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d;

`ifndef PROG_SEQUENCER_STEP_EN
    logic unused_step;
    assign unused_step = step;
`endif

    always_ff @(posedge clk) begin
        if (prog_we && (state_q == StIdle || state_q == StHalt)) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    assign cur_instr = mem[idx_q[ADDR_W-1:0]];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        pc_d       = pc_q;
        iss_d      = iss_q;
        tmo_d      = tmo_q;
        cpu_s_d    = cpu_s_q;
        cpu_load_d = cpu_load_q;
        cpu_in_d   = cpu_in_q;
        done_d     = done_q;
        err_d      = err_q;
        unique case (state_q)
            StIdle, StHalt: begin
                if (start) begin
                    len_d   = prog_len;
                    idx_d   = '0;
                    pc_d    = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (idx_q >= len_q || cur_instr == HALT_OP) begin
                    done_d  = 1'b1;
                    state_d = StHalt;
                end else begin
                    cpu_in_d   = cur_instr;
                    cpu_s_d    = 1'b1;
                    cpu_load_d = 1'b1;
                    iss_d      = '0;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                if (iss_q == IssLast) begin
                    cpu_s_d    = 1'b0;
                    cpu_load_d = 1'b0;
                    tmo_d      = '0;
                    state_d    = StWaitAck;
                end else begin
                    iss_d = iss_q + 1'b1;
                end
            end
            StWaitAck: begin
                if (!cpu_w) begin
                    tmo_d   = '0;
                    state_d = StWaitDone;
                end else if (tmo_q == TmoLast) begin
                    err_d      = 1'b1;
                    cpu_s_d    = 1'b0;
                    cpu_load_d = 1'b0;
                    state_d    = StHalt;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (cpu_w) begin
                    idx_d = idx_q + 1'b1;
                    pc_d  = (pc_q == {ADDR_W{1'b1}}) ? pc_q : pc_q + 1'b1;
`ifdef PROG_SEQUENCER_STEP_EN
                    state_d = StStepHold;
`else
                    state_d = StFetch;
`endif
                end else if (tmo_q == TmoLast) begin
                    err_d      = 1'b1;
                    cpu_s_d    = 1'b0;
                    cpu_load_d = 1'b0;
                    state_d    = StHalt;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
`ifdef PROG_SEQUENCER_STEP_EN
            StStepHold: begin
                if (step) begin
                    state_d = StFetch;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle) && (state_d != StHalt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            len_q      <= '0;
            pc_q       <= '0;
            iss_q      <= '0;
            tmo_q      <= '0;
            cpu_s_q    <= 1'b0;
            cpu_load_q <= 1'b0;
            cpu_in_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            pc_q       <= pc_d;
            iss_q      <= iss_d;
            tmo_q      <= tmo_d;
            cpu_s_q    <= cpu_s_d;
            cpu_load_q <= cpu_load_d;
            cpu_in_q   <= cpu_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cpu_s    = cpu_s_q;
    assign cpu_load = cpu_load_q;
    assign cpu_in   = cpu_in_q;
    assign pc       = pc_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Instruction sequencer that feeds the 16-bit cpu automatically, replacing hand-driven s/load/in stimulus.
- Holds a small program buffer written through a host port.
- On start, issues each instruction to the cpu with the s/load handshake, then waits on the cpu's w (waiting) flag before issuing the next one.
- Sits beside the cpu at the top level and drives its s, load and in pins.

Parameters:
DATA_W, 16, instruction width (matches cpu data_width)
ADDR_W, 4, program buffer address width (depth = 2**ADDR_W)
ISSUE_CYC, 2, cycles cpu_s/cpu_load are held high per issue (>=1)
TIMEOUT_CYC, 64, max cycles spent in either wait state before error
HALT_OP, 16'hE000, encoding that terminates execution without being issued

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
prog_we  in  1  program buffer write enable
prog_addr  in  ADDR_W  program buffer write address
prog_wdata  in  DATA_W  program buffer write data
prog_len  in  ADDR_W+1  instruction count; sampled on accepted start
start  in  1  begin execution at address 0
step  in  1  single-step advance (used only with the optional feature)
cpu_w  in  1  cpu waiting flag (1 = idle, ready for an instruction)
cpu_s  out  1  cpu start
cpu_load  out  1  cpu instruction-register load
cpu_in  out  DATA_W  instruction to cpu
pc  out  ADDR_W  address of the current instruction
busy  out  1  high in any state other than IDLE and HALT
done  out  1  sticky; program finished normally
err  out  1  sticky; a wait state timed out

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - cpu_s=0, cpu_load=0, cpu_in=0, pc=0, busy=0, done=0, err=0.
  - Buffer contents are not reset and are retained across reset.
- All outputs are registered.
- Buffer:
  - Synchronous write when prog_we=1 and state is IDLE or HALT; writes in other states are ignored.
  - Read is combinational at pc.
- States: IDLE, FETCH, ISSUE, WAIT_ACK, WAIT_DONE, HALT.
- IDLE/HALT:
  - start=1 at an edge latches len=prog_len and sets pc=0, done=0, err=0, state=FETCH.
  - start is ignored in every other state.
- FETCH (1 cycle):
  - If pc >= len, or buf[pc]==HALT_OP: done=1, go to HALT.
  - Otherwise cpu_in<=buf[pc], cpu_s<=1, cpu_load<=1, go to ISSUE.
- ISSUE:
  - Hold cpu_s=cpu_load=1 for exactly ISSUE_CYC cycles.
  - Then deassert both and go to WAIT_ACK. cpu_in holds its value until the next FETCH issue.
- WAIT_ACK:
  - Wait for cpu_w==0 (cpu has left its wait state), then go to WAIT_DONE.
- WAIT_DONE:
  - Wait for cpu_w==1 (instruction complete).
  - Then pc<=pc+1, go to FETCH.
  - pc saturates its counter width; len=2**ADDR_W runs the whole buffer and ends with pc=2**ADDR_W-1 plus the len check.
- Timeout:
  - A counter clears on entry to WAIT_ACK and again on entry to WAIT_DONE.
  - If it reaches TIMEOUT_CYC: err=1, cpu_s=cpu_load=0, go to HALT. pc holds the faulting address.
- prog_len=0: start -> FETCH -> HALT with done=1. No issue occurs.
- Latency: start edge -> cpu_s high 2 edges later (IDLE->FETCH->ISSUE).
- Reset asserted mid-operation aborts immediately with the reset values above. The next start reruns from address 0.
- done and err are mutually exclusive and stay set until the next accepted start or reset.

Optional Feature:
- Macro: PROG_SEQUENCER_STEP_EN.
- Defined: adds state STEP_HOLD, entered from WAIT_DONE in place of FETCH.
  - pc increments on the way into STEP_HOLD.
  - The block waits for a step=1 edge, then goes to FETCH.
  - busy stays 1 in STEP_HOLD.
  - The timeout counter is inactive in STEP_HOLD.
- Undefined: the step port exists but is ignored. WAIT_DONE goes straight to FETCH.

Test Plan:
- Normal run:
  - Stimulus: write 16'hD007, 16'hD102, 16'hA148 at addresses 0..2; prog_len=3; start. The cpu model drops w 1 cycle after seeing s and raises it 3 cycles later.
  - Required: cpu_in shows D007, D102, A148 in order; each cpu_s pulse is exactly 2 cycles; done=1 and busy=0 after the third w rise; pc=3.
- Halt opcode:
  - Stimulus: buffer = {D007, E000, D102}; prog_len=3; start.
  - Required: exactly one issue; done=1; pc=1; E000 never appears with cpu_s=1.
- Timeout:
  - Stimulus: the cpu model holds w=1 forever.
  - Required: err=1 exactly TIMEOUT_CYC=64 cycles after WAIT_ACK entry; done=0; cpu_s=0; pc=0.
- Zero length and guards:
  - Stimulus: prog_len=0, start.
  - Required: done=1 within 2 cycles with no cpu_s.
  - Stimulus: prog_we and start asserted while busy.
  - Required: buffer unchanged and run unaffected.
- Reset mid-run:
  - Stimulus: assert reset during WAIT_DONE of instruction 1.
  - Required: all outputs 0 asynchronously, before the next edge; buffer intact; a new start reissues D007 first.
- Step mode (macro defined):
  - Stimulus: run the normal-run program.
  - Required: after each w rise, no cpu_s until a step pulse; three step pulses are required to reach done=1.
